// File: rtl/sb_arbiter_if.sv
// Request/grant/response bundle for one 32-bit system-bus port.
// The master modport issues requests; the slave modport answers them.
interface sb_arbiter_if;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/sb_arbiter.sv
// Two-master / one-slave system-bus arbiter.
// m0 = CPU data port, m1 = debug SBA master, sb = interconnect port.
// Address phases are arbitrated and held across slave stalls; in-order
// responses are steered back using a small FIFO of owner ids.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no stalled address phase; winner chosen fresh every cycle
// S_HOLD | slave stalled the owner's address phase; mux locked to r_owner
module sb_arbiter #(
    parameter int MaxOutstanding = 2,
    parameter int RoundRobin     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    sb_arbiter_if.slave  m0,
    sb_arbiter_if.slave  m1,
    sb_arbiter_if.master sb,
    output logic         err_unexp_rvalid
);

    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_owner;
    logic                      w_owner_nxt;
    logic                      r_rr_prio;
    logic [MaxOutstanding-1:0] r_fifo;
    logic [PtrW-1:0]           r_wptr;
    logic [PtrW-1:0]           r_rptr;
    logic [CntW-1:0]           r_count;
    logic                      r_err;

    logic w_empty;
    logic w_head;
    logic w_pop;
    logic w_block;
    logic w_winner;
    logic w_sel;
    logic w_sel_req;
    logic w_sb_req;
    logic w_push;
    logic w_gnt0;
    logic w_gnt1;

    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rptr];
    assign w_pop   = sb.rvalid & ~w_empty;
    // A response popping this cycle frees a slot, so a full FIFO still grants.
    assign w_block = (r_count == CntMax) & ~w_pop;

    // Pick the candidate master for a fresh address phase.
    always_comb begin
        w_winner = 1'b0;
        if (RoundRobin != 0) begin
            if (m0.req && m1.req) begin
                w_winner = r_rr_prio;
            end else begin
                w_winner = m1.req;
            end
        end else begin
            w_winner = m1.req;
        end
    end

    // State register: IDLE/HOLD and the locked owner.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Next-state logic; a retracted request in HOLD falls back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        case (r_state)
            S_IDLE: begin
                if (w_sb_req && !sb.gnt) begin
                    w_state_nxt = S_HOLD;
                    w_owner_nxt = w_winner;
                end
            end
            S_HOLD: begin
                if (!w_sb_req || sb.gnt) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: address mux select, slave request and per-master grant.
    always_comb begin
        w_sel     = (r_state == S_HOLD) ? r_owner : w_winner;
        w_sel_req = w_sel ? m1.req : m0.req;
        w_sb_req  = w_sel_req & ~w_block;
        w_push    = w_sb_req & sb.gnt;
        w_gnt0    = w_push & ~w_sel;
        w_gnt1    = w_push & w_sel;
    end

    assign sb.req   = w_sb_req;
    assign sb.addr  = w_sel ? m1.addr  : m0.addr;
    assign sb.we    = w_sel ? m1.we    : m0.we;
    assign sb.be    = w_sel ? m1.be    : m0.be;
    assign sb.wdata = w_sel ? m1.wdata : m0.wdata;

    assign m0.gnt    = w_gnt0;
    assign m1.gnt    = w_gnt1;
    assign m0.rvalid = w_pop & ~w_head;
    assign m1.rvalid = w_pop & w_head;
    assign m0.rdata  = sb.rdata;
    assign m1.rdata  = sb.rdata;

    assign err_unexp_rvalid = r_err;

    // Round-robin pointer: after a grant, favour the other master.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_prio <= 1'b0;
        end else if (w_push) begin
            r_rr_prio <= ~w_sel;
        end
    end

    // Outstanding-owner FIFO: push on grant, pop on routed response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fifo  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_sel;
                r_wptr         <= (r_wptr == PtrLast) ? '0 : r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PtrLast) ? '0 : r_rptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Flag a response that has no transaction to belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= sb.rvalid & w_empty;
        end
    end

endmodule

// File: tb/tb_sb_arbiter.sv
// Scoreboard bench for sb_arbiter: one round-robin instance (A) and one
// fixed-priority instance (B). Stimulus pushes cycle-stamped expected
// events; negedge monitors pop and compare whenever a DUT shows activity.
module tb_sb_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic a_err;
    logic b_err;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    typedef struct packed {
        int          cyc;
        logic        g0;
        logic        g1;
        logic        rv0;
        logic        rv1;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] addr;
    } ev_t;

    ev_t exp_a[$];
    ev_t exp_b[$];

    sb_arbiter_if a_m0();
    sb_arbiter_if a_m1();
    sb_arbiter_if a_sb();
    sb_arbiter_if b_m0();
    sb_arbiter_if b_m1();
    sb_arbiter_if b_sb();

    sb_arbiter #(.MaxOutstanding(2), .RoundRobin(1)) u_dut_rr (
        .clk              (clk),
        .rst_n            (rst_n),
        .m0               (a_m0),
        .m1               (a_m1),
        .sb               (a_sb),
        .err_unexp_rvalid (a_err)
    );

    sb_arbiter #(.MaxOutstanding(2), .RoundRobin(0)) u_dut_fp (
        .clk              (clk),
        .rst_n            (rst_n),
        .m0               (b_m0),
        .m1               (b_m1),
        .sb               (b_sb),
        .err_unexp_rvalid (b_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(input int c, input logic g0, input logic g1,
                               input logic rv0, input logic rv1, input logic err,
                               input logic [31:0] rd, input logic [31:0] ad);
        ev_t e;
        e.cyc   = c;
        e.g0    = g0;
        e.g1    = g1;
        e.rv0   = rv0;
        e.rv1   = rv1;
        e.err   = err;
        e.rdata = rd;
        e.addr  = ad;
        return e;
    endfunction

    task automatic cmp_ev(input string tag, input ev_t o, input ev_t e);
        bit ok;
        ok = (o.cyc == e.cyc) && (o.g0 == e.g0) && (o.g1 == e.g1) &&
             (o.rv0 == e.rv0) && (o.rv1 == e.rv1) && (o.err == e.err);
        if (e.rv0 || e.rv1) ok = ok && (o.rdata == e.rdata);
        if (e.g0 || e.g1)   ok = ok && (o.addr == e.addr);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s_event: got cyc=%0d g=%b%b rv=%b%b err=%b rdata=%h addr=%h, want cyc=%0d g=%b%b rv=%b%b err=%b rdata=%h addr=%h",
                     tag, o.cyc, o.g0, o.g1, o.rv0, o.rv1, o.err, o.rdata, o.addr,
                     e.cyc, e.g0, e.g1, e.rv0, e.rv1, e.err, e.rdata, e.addr);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon_a
        ev_t o;
        ev_t e;
        if (mon_en) begin
            o = mk(cyc, a_m0.gnt, a_m1.gnt, a_m0.rvalid, a_m1.rvalid, a_err,
                   a_m1.rvalid ? a_m1.rdata : a_m0.rdata, a_sb.addr);
            if (o.g0 || o.g1 || o.rv0 || o.rv1 || o.err) begin
                if (exp_a.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL A_unexpected: got cyc=%0d g=%b%b rv=%b%b err=%b, want no activity",
                             o.cyc, o.g0, o.g1, o.rv0, o.rv1, o.err);
                end else begin
                    e = exp_a.pop_front();
                    cmp_ev("A", o, e);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_b
        ev_t o;
        ev_t e;
        if (mon_en) begin
            o = mk(cyc, b_m0.gnt, b_m1.gnt, b_m0.rvalid, b_m1.rvalid, b_err,
                   b_m1.rvalid ? b_m1.rdata : b_m0.rdata, b_sb.addr);
            if (o.g0 || o.g1 || o.rv0 || o.rv1 || o.err) begin
                if (exp_b.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL B_unexpected: got cyc=%0d g=%b%b rv=%b%b err=%b, want no activity",
                             o.cyc, o.g0, o.g1, o.rv0, o.rv1, o.err);
                end else begin
                    e = exp_b.pop_front();
                    cmp_ev("B", o, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic idle();
        a_m0.req = 1'b0; a_m1.req = 1'b0; a_sb.gnt = 1'b0; a_sb.rvalid = 1'b0;
        b_m0.req = 1'b0; b_m1.req = 1'b0; b_sb.gnt = 1'b0; b_sb.rvalid = 1'b0;
    endtask

    task automatic init_all();
        idle();
        a_m0.addr = '0; a_m0.we = 1'b0; a_m0.be = 4'hF; a_m0.wdata = '0;
        a_m1.addr = '0; a_m1.we = 1'b0; a_m1.be = 4'hF; a_m1.wdata = '0;
        b_m0.addr = '0; b_m0.we = 1'b0; b_m0.be = 4'hF; b_m0.wdata = '0;
        b_m1.addr = '0; b_m1.we = 1'b0; b_m1.be = 4'hF; b_m1.wdata = '0;
        a_sb.rdata = '0;
        b_sb.rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        init_all();
        step();
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        neg();
        chk("rst_a_sb_req", 32'(a_sb.req), 32'h0);
        chk("rst_a_gnt",    32'({a_m0.gnt, a_m1.gnt}), 32'h0);
        chk("rst_a_rvalid", 32'({a_m0.rvalid, a_m1.rvalid}), 32'h0);
        chk("rst_a_err",    32'(a_err), 32'h0);
        chk("rst_b_sb_req", 32'(b_sb.req), 32'h0);

        // Single m0 read, response one cycle later.
        step();
        a_m0.req = 1'b1; a_m0.addr = 32'h1000_0000; a_m0.we = 1'b0; a_sb.gnt = 1'b1;
        exp_a.push_back(mk(cyc, 1, 0, 0, 0, 0, 32'h0, 32'h1000_0000));
        step();
        a_m0.req = 1'b0; a_sb.gnt = 1'b0; a_sb.rvalid = 1'b1; a_sb.rdata = 32'hDEAD_BEEF;
        exp_a.push_back(mk(cyc, 0, 0, 1, 0, 0, 32'hDEAD_BEEF, 32'h0));
        step();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Both request every cycle: A alternates m0/m1, B always grants m1.
        for (int k = 1; k <= 5; k++) begin
            step();
            a_m0.req = (k <= 4); a_m0.addr = 32'h2000_0000;
            a_m1.req = (k <= 4); a_m1.addr = 32'h3000_0000;
            a_sb.gnt = (k <= 4); a_sb.rvalid = (k >= 2); a_sb.rdata = 32'h10 + 32'(k) - 32'h1;
            b_m0.req = (k <= 4); b_m0.addr = 32'h2000_0000;
            b_m1.req = (k <= 4); b_m1.addr = 32'h3000_0000;
            b_sb.gnt = (k <= 4); b_sb.rvalid = (k >= 2); b_sb.rdata = 32'h20 + 32'(k) - 32'h1;
            exp_a.push_back(mk(cyc, (k <= 4) && (k % 2 == 1), (k <= 4) && (k % 2 == 0),
                               (k >= 2) && (k % 2 == 0), (k >= 2) && (k % 2 == 1), 0,
                               32'h10 + 32'(k) - 32'h1,
                               (k % 2 == 1) ? 32'h2000_0000 : 32'h3000_0000));
            exp_b.push_back(mk(cyc, 0, (k <= 4), 0, (k >= 2), 0,
                               32'h20 + 32'(k) - 32'h1, 32'h3000_0000));
        end
        step();
        idle();

        // Slave stalls 3 cycles while m0 owns the bus and m1 is waiting.
        for (int h = 1; h <= 7; h++) begin
            step();
            a_m0.req = (h <= 4); a_m0.addr = 32'h4000_0000;
            a_m1.req = (h <= 5); a_m1.addr = 32'h5000_0000;
            a_sb.gnt = (h >= 4) && (h <= 5); a_sb.rvalid = (h >= 6);
            a_sb.rdata = 32'h30 + 32'(h) - 32'h5;
            b_m0.req = (h <= 4); b_m0.addr = 32'h4000_0000;
            b_m1.req = (h >= 2) && (h <= 5); b_m1.addr = 32'h5000_0000;
            b_sb.gnt = (h >= 4) && (h <= 5); b_sb.rvalid = (h >= 6);
            b_sb.rdata = 32'h40 + 32'(h) - 32'h5;
            if (h == 4) begin
                exp_a.push_back(mk(cyc, 1, 0, 0, 0, 0, 32'h0, 32'h4000_0000));
                exp_b.push_back(mk(cyc, 1, 0, 0, 0, 0, 32'h0, 32'h4000_0000));
            end
            if (h == 5) begin
                exp_a.push_back(mk(cyc, 0, 1, 0, 0, 0, 32'h0, 32'h5000_0000));
                exp_b.push_back(mk(cyc, 0, 1, 0, 0, 0, 32'h0, 32'h5000_0000));
            end
            if (h == 6) begin
                exp_a.push_back(mk(cyc, 0, 0, 1, 0, 0, 32'h31, 32'h0));
                exp_b.push_back(mk(cyc, 0, 0, 1, 0, 0, 32'h41, 32'h0));
            end
            if (h == 7) begin
                exp_a.push_back(mk(cyc, 0, 0, 0, 1, 0, 32'h32, 32'h0));
                exp_b.push_back(mk(cyc, 0, 0, 0, 1, 0, 32'h42, 32'h0));
            end
            if (h <= 3) begin
                neg();
                chk("A_hold_addr", a_sb.addr, 32'h4000_0000);
                chk("B_hold_addr", b_sb.addr, 32'h4000_0000);
                chk("A_hold_req",  32'(a_sb.req), 32'h1);
            end
        end
        step();
        idle();

        // Fill to MaxOutstanding=2; third grant lands with the first response.
        for (int f = 1; f <= 8; f++) begin
            step();
            a_m0.req = (f <= 6); a_m0.addr = 32'h6000_0000;
            a_sb.gnt = (f <= 6); a_sb.rvalid = (f >= 6);
            a_sb.rdata = 32'h50 + 32'(f) - 32'h5;
            if (f <= 2) exp_a.push_back(mk(cyc, 1, 0, 0, 0, 0, 32'h0, 32'h6000_0000));
            if (f == 6) exp_a.push_back(mk(cyc, 1, 0, 1, 0, 0, 32'h51, 32'h6000_0000));
            if (f >= 7) exp_a.push_back(mk(cyc, 0, 0, 1, 0, 0, 32'h50 + 32'(f) - 32'h5, 32'h0));
            if (f >= 3 && f <= 5) begin
                neg();
                chk("full_sb_req", 32'(a_sb.req), 32'h0);
            end
        end
        step();
        idle();

        // m1 write then m0 read outstanding; responses route in order.
        step();
        a_m1.req = 1'b1; a_m1.we = 1'b1; a_m1.be = 4'b0011;
        a_m1.addr = 32'h7000_0000; a_m1.wdata = 32'hA5A5_A5A5; a_sb.gnt = 1'b1;
        exp_a.push_back(mk(cyc, 0, 1, 0, 0, 0, 32'h0, 32'h7000_0000));
        neg();
        chk("wr_sb_we",    32'(a_sb.we), 32'h1);
        chk("wr_sb_wdata", a_sb.wdata, 32'hA5A5_A5A5);
        chk("wr_sb_be",    32'(a_sb.be), 32'h3);
        step();
        a_m1.req = 1'b0; a_m1.we = 1'b0;
        a_m0.req = 1'b1; a_m0.we = 1'b0; a_m0.addr = 32'h7000_0004;
        exp_a.push_back(mk(cyc, 1, 0, 0, 0, 0, 32'h0, 32'h7000_0004));
        neg();
        chk("rd_sb_we", 32'(a_sb.we), 32'h0);
        step();
        idle();
        step();
        a_sb.rvalid = 1'b1; a_sb.rdata = 32'h1;
        exp_a.push_back(mk(cyc, 0, 0, 0, 1, 0, 32'h1, 32'h0));
        step();
        a_sb.rdata = 32'h2;
        exp_a.push_back(mk(cyc, 0, 0, 1, 0, 0, 32'h2, 32'h0));
        step();
        idle();

        // Unexpected response: registered one-cycle error pulse.
        step();
        a_sb.rvalid = 1'b1; a_sb.rdata = 32'h99;
        exp_a.push_back(mk(cyc + 1, 0, 0, 0, 0, 1, 32'h0, 32'h0));
        neg();
        chk("err_not_yet", 32'(a_err), 32'h0);
        step();
        idle();
        neg();
        chk("err_pulse", 32'(a_err), 32'h1);
        step();
        neg();
        chk("err_cleared", 32'(a_err), 32'h0);

        // Reset with two outstanding: later responses become errors.
        step();
        a_m0.req = 1'b1; a_m0.addr = 32'h8000_0000; a_sb.gnt = 1'b1;
        exp_a.push_back(mk(cyc, 1, 0, 0, 0, 0, 32'h0, 32'h8000_0000));
        step();
        a_m0.req = 1'b0; a_m1.req = 1'b1; a_m1.addr = 32'h8000_0010;
        exp_a.push_back(mk(cyc, 0, 1, 0, 0, 0, 32'h0, 32'h8000_0010));
        step();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        a_sb.rvalid = 1'b1; a_sb.rdata = 32'h61;
        exp_a.push_back(mk(cyc + 1, 0, 0, 0, 0, 1, 32'h0, 32'h0));
        step();
        a_sb.rdata = 32'h62;
        exp_a.push_back(mk(cyc + 1, 0, 0, 0, 0, 1, 32'h0, 32'h0));
        step();
        idle();
        repeat (3) step();

        neg();
        chk("A_queue_drained", 32'(exp_a.size()), 32'h0);
        chk("B_queue_drained", 32'(exp_b.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sb_arbiter.md
Name: sb_arbiter

Overview:
- Two-master, one-slave arbiter for the 32-bit system bus.
- Master 0 is the CPU data port; master 1 is the debug module system-bus-access (SBA) master. The slave is the system bus/interconnect port.
- Both sides use the req/gnt/rvalid protocol. The address phase completes on req&gnt; the response phase is a one-cycle rvalid, returned in order.
- The block selects a master per address phase, holds the selection while the slave stalls, and routes each in-order response back to the master that issued it.

Parameters:
- MaxOutstanding, 2: maximum accepted-but-unanswered transactions; legal range 1..4.
- RoundRobin, 1: 1 = round-robin between masters; 0 = fixed priority, master 1 (debug) wins.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- m0_req  in  1  CPU request
- m0_addr  in  32  CPU address
- m0_we  in  1  CPU write enable
- m0_be  in  4  CPU byte enables
- m0_wdata  in  32  CPU write data
- m0_gnt  out  1  CPU grant
- m0_rvalid  out  1  CPU response valid
- m0_rdata  out  32  CPU read data
- m1_req, m1_addr, m1_we, m1_be, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same directions and widths as m0_*, for the debug SBA master
- sb_req  out  1  slave request
- sb_addr  out  32  slave address
- sb_we  out  1  slave write enable
- sb_be  out  4  slave byte enables
- sb_wdata  out  32  slave write data
- sb_gnt  in  1  slave grant
- sb_rvalid  in  1  slave response valid
- sb_rdata  in  32  slave read data
- err_unexp_rvalid  out  1  one-cycle pulse: sb_rvalid arrived with no outstanding transaction

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; outstanding FIFO is emptied; round-robin pointer is set to favour m0; err_unexp_rvalid is registered 0.
  - All other outputs are combinational and follow from this state: with the FIFO empty, m0_gnt, m1_gnt, m0_rvalid and m1_rvalid are 0.
- State machine IDLE / HOLD(owner):
  - IDLE with FIFO not full: pick a winner among asserted m*_req.
    - RoundRobin=1: winner is the master not granted last, if it is requesting.
    - RoundRobin=0: m1 always wins when requesting.
  - The winner's address phase drives sb_* combinationally in the same cycle. sb_req=0 when no one requests or the FIFO is full.
  - sb_gnt=1 in the same cycle: m<winner>_gnt=1, push the owner id into the FIFO, update the RR pointer, stay IDLE.
  - sb_gnt=0: go to HOLD(winner).
  - HOLD(owner): the mux is locked to owner; the other master's req is ignored. Leave to IDLE on sb_gnt, with push and grant as above.
  - The protocol forbids retracting req before gnt. If the owner deasserts req anyway, return to IDLE with no push.
  - Loser gnt is always 0. Grant latency from req is 0 cycles when the slave grants immediately.
- Outstanding FIFO:
  - Depth MaxOutstanding, 1-bit entries, count width clog2(MaxOutstanding+1).
  - While count==MaxOutstanding: sb_req=0 and no gnt to either master.
  - Push and pop in the same cycle leave count unchanged, so a full FIFO can accept a new grant in the same cycle a response pops.
  - Pointers wrap modulo MaxOutstanding.
- Response routing (combinational):
  - sb_rvalid with FIFO non-empty: m<head>_rvalid=1 and m<head>_rdata=sb_rdata; pop the head.
  - The non-head master's rvalid is 0, and its rdata is also driven with sb_rdata (don't-care).
  - sb_rvalid with FIFO empty: no master rvalid; err_unexp_rvalid=1 on the next cycle (registered). FIFO state is unchanged.
- Same-cycle cases: a grant and a response in the same cycle are independent. A response for an earlier transaction may arrive in the same cycle as a new grant, and each is handled as above.
- Reset mid-operation clears the FIFO. Responses already in flight are then reported as err_unexp_rvalid, not delivered.

Test Plan:
- Only m0 requests a read of 0x1000_0000; slave grants the same cycle and returns rvalid with rdata 0xDEAD_BEEF one cycle later -> m0_gnt=1 in the request cycle; m0_rvalid=1 with 0xDEAD_BEEF; m1_rvalid stays 0.
- RoundRobin=1, both masters request continuously, slave always grants -> grants alternate m0, m1, m0, m1. With RoundRobin=0 -> m1 is granted every cycle.
- Slave holds sb_gnt=0 for 3 cycles while m0 owns the bus and m1 asserts req -> sb_addr stays at m0's address for all 3 cycles; m0 is granted on the 4th; m1 is granted afterwards.
- MaxOutstanding=2, slave grants immediately and delays rvalid by 5 cycles -> after 2 grants sb_req=0 and both gnt=0. The third grant occurs in the same cycle as the first rvalid.
- Interleaved m1 write then m0 read outstanding; two rvalids with rdata 0x1, 0x2 -> m1_rvalid sees 0x1 first, then m0_rvalid sees 0x2.
- sb_rvalid pulsed with FIFO empty -> err_unexp_rvalid=1 for exactly 1 cycle. Separately: rst_n low for 1 cycle with 2 outstanding transactions -> FIFO is empty afterwards and no m*_rvalid follows.
